// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg -- shared CPU constants for the multiply/divide unit.
// Holds the R-type funct codes the unit decodes, the FSM state encoding,
// the iteration count of the iterative engine and small helper functions.
package muldiv_ctrl_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    // One iteration per result bit.
    localparam int unsigned ITER_COUNT = 32;
    // Down-counter start value: the iteration with count 0 is the last one.
    localparam logic [4:0]  ITER_LOAD  = 5'(ITER_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // True for every funct code this unit owns.
    function automatic logic is_muldiv_funct(input logic [5:0] f);
        case (f)
            FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    // Two's-complement negation of a 32-bit word.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return 32'd0 - v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if -- EX-stage <-> multiply/divide unit signal bundle.
//   master (pipeline): drives start, funct, rs_val, rt_val, flush;
//                      observes stall, busy, result, hi, lo.
//   slave  (muldiv_ctrl): the opposite directions.
interface muldiv_ctrl_if;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, funct, rs_val, rt_val, flush,
        input  stall, busy, result, hi, lo
    );

    modport slave (
        input  start, funct, rs_val, rt_val, flush,
        output stall, busy, result, hi, lo
    );
endinterface

// File: rtl/muldiv_core.sv
// muldiv_core -- iterative unsigned shift-add multiplier / restoring divider.
//   i_load          : capture operands, clear high half, arm the counter
//   i_run, i_is_div : perform one iteration (multiply or divide step)
//   i_op_a, i_op_b  : multiplier/dividend and multiplicand/divisor (magnitudes)
//   o_last          : the iteration running this cycle is the final one
//   o_acc           : product, or {remainder, quotient} after 32 iterations
module muldiv_core
    import muldiv_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_load,
    input  logic        i_run,
    input  logic        i_is_div,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    output logic        o_last,
    output logic [63:0] o_acc
);

    logic [63:0] r_acc;
    logic [31:0] r_opb;
    logic [4:0]  r_cnt;

    logic [32:0] w_add;
    logic [63:0] w_mul_nxt;
    logic [64:0] w_sh;
    logic [32:0] w_diff;
    logic [63:0] w_div_nxt;

    // Multiply step: conditionally add the multiplicand into the high half,
    // then shift right, keeping the carry as the new MSB.
    assign w_add     = {1'b0, r_acc[63:32]} + {1'b0, r_opb};
    assign w_mul_nxt = r_acc[0] ? {w_add, r_acc[31:1]} : {1'b0, r_acc[63:1]};

    // Restoring divide step: shift left, trial-subtract the divisor from the
    // 33-bit partial remainder and keep the difference when it is non-negative.
    assign w_sh      = {r_acc, 1'b0};
    assign w_diff    = w_sh[64:32] - {1'b0, r_opb};
    assign w_div_nxt = w_diff[32] ? w_sh[63:0] : {w_diff[31:0], w_sh[31:1], 1'b1};

    assign o_last = (r_cnt == 5'd0);
    assign o_acc  = r_acc;

    // Operand, accumulator and iteration-counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= 64'd0;
            r_opb <= 32'd0;
            r_cnt <= 5'd0;
        end else if (i_load) begin
            r_acc <= {32'd0, i_op_a};
            r_opb <= i_op_b;
            r_cnt <= ITER_LOAD;
        end else if (i_run) begin
            r_acc <= i_is_div ? w_div_nxt : w_mul_nxt;
            // Wraps after the last step; the controller has left MUL/DIV by then.
            r_cnt <= r_cnt - 5'd1;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl -- HI/LO multiply/divide unit of the EX stage.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus (slave)    : start/funct/rs_val/rt_val/flush in; stall/busy/result/hi/lo out
// Owns the IDLE/MUL/DIV/DONE FSM, the HI/LO registers, pipeline stall and the
// sign fix-up of signed operations; the engine iterates on magnitudes only.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    muldiv_ctrl_if.slave bus
);

    state_t      r_state, w_state_nxt;
    logic        r_op_div, r_neg_res, r_neg_rem, r_div0;
    logic [31:0] r_hi, r_lo;

    logic        w_accept, w_busy, w_load, w_run, w_last;
    logic        w_is_signed, w_a_neg, w_b_neg, w_load_div;
    logic        w_hi_we, w_lo_we;
    logic [31:0] w_hi_nxt, w_lo_nxt, w_op_a, w_op_b, w_quo, w_rem, w_result;
    logic [63:0] w_acc, w_prod;

    // A flush in the same cycle squashes the instruction being presented.
    assign w_accept    = bus.start & ~bus.flush;
    assign w_busy      = (r_state != ST_IDLE);
    assign w_is_signed = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);
    assign w_load_div  = (bus.funct == FUNCT_DIV)  || (bus.funct == FUNCT_DIVU);
    assign w_a_neg     = w_is_signed & bus.rs_val[31];
    assign w_b_neg     = w_is_signed & bus.rt_val[31];
    assign w_op_a      = w_a_neg ? neg32(bus.rs_val) : bus.rs_val;
    assign w_op_b      = w_b_neg ? neg32(bus.rt_val) : bus.rt_val;

    muldiv_core u_core (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_load   (w_load),
        .i_run    (w_run),
        .i_is_div (r_state == ST_DIV),
        .i_op_a   (w_op_a),
        .i_op_b   (w_op_b),
        .o_last   (w_last),
        .o_acc    (w_acc)
    );

    // Sign fix-up. Quotient is negative when operand signs differ; remainder
    // takes the dividend's sign. Divide by zero forces an all-ones quotient;
    // the engine already leaves the dividend as remainder, so hi == rs_val.
    assign w_prod = r_neg_res ? (64'd0 - w_acc) : w_acc;
    assign w_quo  = r_div0 ? 32'hFFFF_FFFF
                           : (r_neg_res ? neg32(w_acc[31:0]) : w_acc[31:0]);
    assign w_rem  = r_neg_rem ? neg32(w_acc[63:32]) : w_acc[63:32];

    // Next-state, engine control and HI/LO write decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_run       = 1'b0;
        w_hi_we     = 1'b0;
        w_lo_we     = 1'b0;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (bus.funct)
                        FUNCT_MULT, FUNCT_MULTU: begin
                            w_state_nxt = ST_MUL;
                            w_load      = 1'b1;
                        end
                        FUNCT_DIV, FUNCT_DIVU: begin
                            w_state_nxt = ST_DIV;
                            w_load      = 1'b1;
                        end
                        FUNCT_MTHI: begin
                            w_hi_we  = 1'b1;
                            w_hi_nxt = bus.rs_val;
                        end
                        FUNCT_MTLO: begin
                            w_lo_we  = 1'b1;
                            w_lo_nxt = bus.rs_val;
                        end
                        default: w_state_nxt = ST_IDLE;
                    endcase
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (bus.flush) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_run       = 1'b1;
                    w_state_nxt = w_last ? ST_DONE : r_state;
                end
            end
            ST_DONE: begin
                // Flush wins over completion: HI/LO keep their old values.
                if (bus.flush) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_hi_we     = 1'b1;
                    w_lo_we     = 1'b1;
                    w_hi_nxt    = r_op_div ? w_rem : w_prod[63:32];
                    w_lo_nxt    = r_op_div ? w_quo : w_prod[31:0];
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operation kind and sign flags captured with the operands.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
        end else if (w_load) begin
            r_op_div  <= w_load_div;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_div0    <= (bus.rt_val == 32'd0);
        end
    end

    // Architectural HI/LO registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (w_hi_we) r_hi <= w_hi_nxt;
            if (w_lo_we) r_lo <= w_lo_nxt;
        end
    end

    // MFHI/MFLO read mux.
    always_comb begin
        w_result = 32'd0;
        case (bus.funct)
            FUNCT_MFHI: w_result = r_hi;
            FUNCT_MFLO: w_result = r_lo;
            default:    w_result = 32'd0;
        endcase
    end

    assign bus.busy   = w_busy;
    assign bus.stall  = bus.start & w_busy & is_muldiv_funct(bus.funct);
    assign bus.result = w_result;
    assign bus.hi     = r_hi;
    assign bus.lo     = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl -- directed self-checking bench for muldiv_ctrl.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic clock;
    logic reset_n;

    muldiv_ctrl_if bus();

    muldiv_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        bus.start  = 1'b0;
        bus.funct  = 6'd0;
        bus.rs_val = 32'd0;
        bus.rt_val = 32'd0;
        bus.flush  = 1'b0;
    endtask

    // Present one instruction for one edge, then count busy cycles (bounded).
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output logic [31:0] lo_last);
        bus.start  = 1'b1;
        bus.funct  = f;
        bus.rs_val = a;
        bus.rt_val = b;
        tick();
        bus.start  = 1'b0;
        bus.funct  = 6'd0;
        cyc        = 0;
        lo_last    = bus.lo;
        while (bus.busy === 1'b1 && cyc < 100) begin
            lo_last = bus.lo;
            cyc++;
            tick();
        end
    endtask

    task automatic op_check(input string tag, input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int          cyc;
        logic [31:0] lo_last;
        run_op(f, a, b, cyc, lo_last);
        check({tag, "_busycyc"}, 64'(cyc), 64'd33);
        check({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
        check({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
    endtask

    initial begin
        int          cyc;
        int          stall_bad;
        logic [31:0] lo_last;

        drive_idle();
        reset_n   = 1'b0;
        bus.start = 1'b1;
        bus.funct = FUNCT_MFHI;
        #2;
        check("rst_busy",   {63'd0, bus.busy},   64'd0);
        check("rst_stall",  {63'd0, bus.stall},  64'd0);
        check("rst_result", {32'd0, bus.result}, 64'd0);
        check("rst_hilo",   {bus.hi, bus.lo},    64'd0);
        tick();
        drive_idle();
        reset_n = 1'b1;
        tick();

        // MULT -2 * 3: 33 busy cycles, HI/LO still old during DONE.
        run_op(FUNCT_MULT, 32'hFFFF_FFFE, 32'd3, cyc, lo_last);
        check("mult_busycyc", 64'(cyc), 64'd33);
        check("mult_lo_in_done", {32'd0, lo_last}, 64'd0);
        check("mult_hi", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFFF);
        check("mult_lo", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFFA);

        op_check("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        op_check("mult_min",  FUNCT_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        op_check("div_m7_2",  FUNCT_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        op_check("div_7_m2",  FUNCT_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        op_check("divu_7_0",  FUNCT_DIVU,  32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF);
        op_check("div_m7_0",  FUNCT_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
        op_check("div_ovf",   FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        op_check("divu_100_7",FUNCT_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E);

        // MTHI/MTLO then MFHI/MFLO, no stall.
        bus.start = 1'b1; bus.funct = FUNCT_MTHI; bus.rs_val = 32'h1234_5678;
        #1;
        check("mthi_stall", {63'd0, bus.stall}, 64'd0);
        tick();
        bus.funct = FUNCT_MTLO; bus.rs_val = 32'hCAFE_F00D;
        tick();
        bus.funct = FUNCT_MFHI; bus.rs_val = 32'd0;
        #1;
        check("mfhi_result", {32'd0, bus.result}, 64'h0000_0000_1234_5678);
        check("mfhi_stall",  {63'd0, bus.stall},  64'd0);
        bus.funct = FUNCT_MFLO;
        #1;
        check("mflo_result", {32'd0, bus.result}, 64'h0000_0000_CAFE_F00D);
        bus.funct = 6'b100000; bus.rs_val = 32'hDEAD_BEEF;
        #1;
        check("other_result", {32'd0, bus.result}, 64'd0);
        tick();
        check("other_noeffect", {31'd0, bus.busy, bus.hi}, 64'h0000_0000_1234_5678);

        // Flush together with start in IDLE ignores the instruction.
        bus.flush = 1'b1; bus.funct = FUNCT_MULT; bus.rs_val = 32'd5; bus.rt_val = 32'd5;
        tick();
        check("flush_start_busy", {63'd0, bus.busy}, 64'd0);
        bus.funct = FUNCT_MTLO; bus.rs_val = 32'd0;
        tick();
        check("flush_mtlo_lo", {32'd0, bus.lo}, 64'h0000_0000_CAFE_F00D);
        drive_idle();

        // Flush at iteration 10 of DIVU: HI/LO keep their values.
        bus.start = 1'b1; bus.funct = FUNCT_DIVU; bus.rs_val = 32'd1000; bus.rt_val = 32'd3;
        tick();
        drive_idle();
        for (int i = 0; i < 9; i++) tick();
        bus.flush = 1'b1;
        #1;
        check("flush_it10_busy_before", {63'd0, bus.busy}, 64'd1);
        tick();
        bus.flush = 1'b0;
        check("flush_it10_busy", {63'd0, bus.busy}, 64'd0);
        check("flush_it10_hilo", {bus.hi, bus.lo}, 64'h1234_5678_CAFE_F00D);

        op_check("divu_1000_3", FUNCT_DIVU, 32'd1000, 32'd3, 32'h0000_0001, 32'h0000_014D);

        // Flush while in DONE: completion suppressed.
        bus.start = 1'b1; bus.funct = FUNCT_MULTU; bus.rs_val = 32'd6; bus.rt_val = 32'd7;
        tick();
        drive_idle();
        for (int i = 0; i < 32; i++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_done_busy", {63'd0, bus.busy}, 64'd0);
        check("flush_done_hilo", {bus.hi, bus.lo}, 64'h0000_0001_0000_014D);

        // MFLO presented 5 cycles after MULTU stalls until busy falls.
        bus.start = 1'b1; bus.funct = FUNCT_MULTU; bus.rs_val = 32'd6; bus.rt_val = 32'd7;
        tick();
        drive_idle();
        tick();
        bus.start = 1'b1; bus.funct = 6'b100000;
        #1;
        check("busy_other_stall", {63'd0, bus.stall}, 64'd0);
        drive_idle();
        tick(); tick(); tick();
        bus.start = 1'b1; bus.funct = FUNCT_MFLO;
        stall_bad = 0;
        cyc = 0;
        #1;
        while (bus.busy === 1'b1 && cyc < 100) begin
            if (bus.stall !== 1'b1) stall_bad++;
            cyc++;
            tick();
        end
        check("mflo_stall_cycles", 64'(cyc), 64'd29);
        check("mflo_stall_gaps", 64'(stall_bad), 64'd0);
        check("mflo_after_stall", {63'd0, bus.stall}, 64'd0);
        check("mflo_after_result", {32'd0, bus.result}, 64'h0000_0000_0000_002A);
        check("multu_6_7_hi", {32'd0, bus.hi}, 64'd0);
        drive_idle();
        tick();

        // Asynchronous reset mid-MULT.
        bus.start = 1'b1; bus.funct = FUNCT_MULT; bus.rs_val = 32'd5; bus.rt_val = 32'hFFFF_FFFD;
        tick();
        drive_idle();
        for (int i = 0; i < 5; i++) tick();
        bus.start = 1'b1; bus.funct = FUNCT_MFLO;
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_busy",   {63'd0, bus.busy},   64'd0);
        check("midrst_stall",  {63'd0, bus.stall},  64'd0);
        check("midrst_result", {32'd0, bus.result}, 64'd0);
        check("midrst_hilo",   {bus.hi, bus.lo},    64'd0);
        #1;
        reset_n = 1'b1;
        drive_idle();
        tick();
        op_check("mult_after_rst", FUNCT_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
